// File: rtl/usbdev_remote_wake.sv
// usbdev_remote_wake: remote-wakeup resume signaling generator.
// Waits for the bus to be idle long enough while suspended, drives K for a
// fixed time, then releases the bus and waits for the host to resume the link.
module usbdev_remote_wake #(
  parameter logic [14:0] IdleMinUs  = 15'd5000,
  parameter logic [14:0] KDriveUs   = 15'd2000,
  parameter logic [14:0] HostWaitUs = 15'd20000
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       us_tick_i,
  input  logic       wake_en_i,
  input  logic       wake_req_i,
  input  logic       link_suspend_i,
  input  logic       link_reset_i,
  input  logic       link_disconnect_i,
  input  logic       rx_idle_det_i,
  output logic       wake_oe_o,
  output logic       wake_k_o,
  output logic       wake_busy_o,
  output logic       wake_done_o,
  output logic       wake_rejected_o,
  output logic       wake_aborted_o,
  output logic       wake_fail_o,
  output logic [2:0] wake_state_o
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWait    = 3'd1,
    StDrive   = 3'd2,
    StRelease = 3'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [14:0] r_idle_cnt;
  logic [14:0] r_timer;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_rejected;
  logic        r_aborted;
  logic        r_fail;

  logic        w_quiet;
  logic        w_idle_ok;
  logic        w_k_last;
  logic        w_host_last;
  logic        w_timed;
  logic        w_done;
  logic        w_rejected;
  logic        w_aborted;
  logic        w_fail;

  // Bus counts as quiet only while suspended, receiver idle and we are not driving K ourselves.
  assign w_quiet     = link_suspend_i & rx_idle_det_i & ~r_oe;
  assign w_idle_ok   = (r_idle_cnt == IdleMinUs);
  assign w_k_last    = us_tick_i & (r_timer == (KDriveUs - 15'd1));
  assign w_host_last = us_tick_i & (r_timer == (HostWaitUs - 15'd1));
  assign w_timed     = (r_state == StDrive) | (r_state == StRelease);

  // Continuous bus-idle time in microseconds, saturating at the required minimum.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt <= '0;
    end else if (!w_quiet) begin
      r_idle_cnt <= '0;
    end else if (us_tick_i && (r_idle_cnt < IdleMinUs)) begin
      r_idle_cnt <= r_idle_cnt + 15'd1;
    end
  end

  // Per-state microsecond timer: restarts on every state change, counts in Drive/Release.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      r_timer <= '0;
    end else if (us_tick_i && w_timed && (r_timer != 15'h7FFF)) begin
      r_timer <= r_timer + 15'd1;
    end
  end

  // Next-state and event decode; reset/disconnect abort wins over every other transition.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_rejected   = 1'b0;
    w_aborted    = 1'b0;
    w_fail       = 1'b0;
    if ((r_state != StIdle) && (link_reset_i || link_disconnect_i)) begin
      w_state_next = StIdle;
      w_aborted    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (wake_req_i) begin
            if (wake_en_i && link_suspend_i) begin
              w_state_next = StWait;
            end else begin
              w_rejected = 1'b1;
            end
          end
        end
        StWait: begin
          if (!link_suspend_i || !wake_en_i) begin
            w_state_next = StIdle;
            w_aborted    = 1'b1;
          end else if (w_idle_ok) begin
            w_state_next = StDrive;
          end
        end
        StDrive: begin
          if (w_k_last) begin
            w_state_next = StRelease;
          end
        end
        StRelease: begin
          if (!link_suspend_i) begin
            w_state_next = StIdle;
            w_done       = 1'b1;
          end else if (w_host_last) begin
            w_state_next = StIdle;
            w_fail       = 1'b1;
          end
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // State register plus registered outputs derived from the upcoming state.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rejected <= 1'b0;
      r_aborted  <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_oe       <= (w_state_next == StDrive);
      r_busy     <= (w_state_next != StIdle);
      r_done     <= w_done;
      r_rejected <= w_rejected;
      r_aborted  <= w_aborted;
      r_fail     <= w_fail;
    end
  end

  assign wake_oe_o       = r_oe;
  assign wake_k_o        = r_oe;
  assign wake_busy_o     = r_busy;
  assign wake_done_o     = r_done;
  assign wake_rejected_o = r_rejected;
  assign wake_aborted_o  = r_aborted;
  assign wake_fail_o     = r_fail;
  assign wake_state_o    = r_state;

endmodule
